// File: rtl/phase_report_sched.sv
// rtl/phase_report_sched.sv - telemetry arbiter and 7-byte frame sender for the GPSDO UART
//
// Purpose:
//   Three requesters share one byte-wide UART transmitter:
//     - phase measurements
//     - comparator no-pair timeouts
//     - an optional heartbeat carrying PWM_Duty
//   Each requester has a pending flag and a payload register.
//   Arbitration is fixed priority (Meas > Tmo > HB) and is decided in IDLE.
//   The winner is sent as the frame {SYNC, type, value[31:24..7:0], xor(b1..b5)}.
//   Each byte uses a strobe / busy-rise / busy-fall handshake.
//   If busy never rises, the frame is aborted and Frame_Err is pulsed.
//
// Optional feature:
//   PHASE_RPT_HEARTBEAT_EN - when defined, builds the heartbeat counter and
//   requester (type 3 frames). When undefined, PWM_Duty and HB_PERIOD are unused.
//
// Ports:
//   CLK_SYS     in   system clock
//   CLK_RST     in   synchronous active-low reset
//   Meas_Valid  in   one-cycle pulse: new phase measurement
//   Meas_Phase  in   32-bit phase count (sampled with Meas_Valid / Tmo_Valid)
//   Meas_Order  in   0 = GPS leads, 1 = Local leads (sampled with Meas_Valid)
//   Meas_Lock   in   lock state, sampled with any request
//   Tmo_Valid   in   one-cycle pulse: comparator no-pair timeout
//   PWM_Duty    in   32-bit duty, sampled for the heartbeat
//   Uart_Busy   in   UART transmitter busy
//   Uart_En     out  one-cycle byte strobe
//   Uart_Data   out  byte to send, held between strobes
//   Frame_Done  out  one-cycle pulse after the last byte is accepted
//   Frame_Err   out  one-cycle pulse on busy-handshake timeout
//   Ovr_Cnt     out  saturating count of overwritten pending requests

module phase_report_sched #(
  parameter int unsigned HB_PERIOD    = 32'd50000000,
  parameter int unsigned BUSY_TIMEOUT = 32'd1023,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        CLK_SYS,
  input  logic        CLK_RST,
  input  logic        Meas_Valid,
  input  logic [31:0] Meas_Phase,
  input  logic        Meas_Order,
  input  logic        Meas_Lock,
  input  logic        Tmo_Valid,
  input  logic [31:0] PWM_Duty,
  input  logic        Uart_Busy,
  output logic        Uart_En,
  output logic [7:0]  Uart_Data,
  output logic        Frame_Done,
  output logic        Frame_Err,
  output logic [7:0]  Ovr_Cnt
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [55:0] frame_q, frame_d;
  logic        uart_en_q, uart_en_d;
  logic [7:0]  uart_data_q, uart_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  ovr_q, ovr_d;
  logic [8:0]  ovr_sum;

  logic        meas_pend_q, meas_pend_d;
  logic [33:0] meas_pl_q, meas_pl_d;
  logic        tmo_pend_q, tmo_pend_d;
  logic [32:0] tmo_pl_q, tmo_pl_d;
  logic        ovr_meas, ovr_tmo, ovr_hb;

  logic        hb_pend;
  logic [32:0] hb_pl;

  logic        grant_meas, grant_tmo, grant_hb;
  logic [7:0]  cur_byte;

  function automatic logic [55:0] build_frame(input logic [7:0] typ, input logic [31:0] val);
    logic [7:0] csum;
    csum = typ ^ val[31:24] ^ val[23:16] ^ val[15:8] ^ val[7:0];
    return {SYNC_BYTE, typ, val, csum};
  endfunction

  // Byte 0 sits in the top byte of frame_q, so idx_q selects from MSB down.
  always_comb begin
    cur_byte = frame_q[55:48];
    case (idx_q)
      3'd1:    cur_byte = frame_q[47:40];
      3'd2:    cur_byte = frame_q[39:32];
      3'd3:    cur_byte = frame_q[31:24];
      3'd4:    cur_byte = frame_q[23:16];
      3'd5:    cur_byte = frame_q[15:8];
      3'd6:    cur_byte = frame_q[7:0];
      default: cur_byte = frame_q[55:48];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    frame_d     = frame_q;
    uart_en_d   = 1'b0;
    uart_data_d = uart_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    grant_meas  = 1'b0;
    grant_tmo   = 1'b0;
    grant_hb    = 1'b0;
    case (state_q)
      IDLE: begin
        if (meas_pend_q) begin
          grant_meas = 1'b1;
          frame_d    = build_frame({meas_pl_q[33], meas_pl_q[32], 6'h01}, meas_pl_q[31:0]);
        end else if (tmo_pend_q) begin
          grant_tmo = 1'b1;
          frame_d   = build_frame({1'b0, tmo_pl_q[32], 6'h02}, tmo_pl_q[31:0]);
        end else if (hb_pend) begin
          grant_hb = 1'b1;
          frame_d  = build_frame({1'b0, hb_pl[32], 6'h03}, hb_pl[31:0]);
        end
        if (meas_pend_q || tmo_pend_q || hb_pend) begin
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!Uart_Busy) begin
          uart_en_d   = 1'b1;
          uart_data_d = cur_byte;
          tmo_d       = '0;
          state_d     = WAIT_HI;
        end
      end
      WAIT_HI: begin
        // Counts cycles without a busy rise. The abort fires on the
        // BUSY_TIMEOUT-th cycle after the strobe.
        if (Uart_Busy) begin
          state_d = WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      WAIT_LO: begin
        if (!Uart_Busy) begin
          if (idx_q == 3'd6) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request arriving in its own grant cycle re-arms pending with the new
  // payload. The old payload is already in the frame, so this is not an overrun.
  always_comb begin
    meas_pend_d = meas_pend_q & ~grant_meas;
    meas_pl_d   = meas_pl_q;
    ovr_meas    = 1'b0;
    if (Meas_Valid) begin
      meas_pend_d = 1'b1;
      meas_pl_d   = {Meas_Order, Meas_Lock, Meas_Phase};
      ovr_meas    = meas_pend_q & ~grant_meas;
    end
    tmo_pend_d = tmo_pend_q & ~grant_tmo;
    tmo_pl_d   = tmo_pl_q;
    ovr_tmo    = 1'b0;
    if (Tmo_Valid) begin
      tmo_pend_d = 1'b1;
      tmo_pl_d   = {Meas_Lock, Meas_Phase};
      ovr_tmo    = tmo_pend_q & ~grant_tmo;
    end
    // Up to three sources can overrun in one cycle. The 9-bit sum cannot wrap.
    ovr_sum = {1'b0, ovr_q} + {8'd0, ovr_meas} + {8'd0, ovr_tmo} + {8'd0, ovr_hb};
    ovr_d   = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
  end

`ifdef PHASE_RPT_HEARTBEAT_EN
  logic        hb_pend_q, hb_pend_d;
  logic [32:0] hb_pl_q, hb_pl_d;
  logic [31:0] hb_cnt_q, hb_cnt_d;
  logic        hb_fire;

  always_comb begin
    hb_fire   = (hb_cnt_q == 32'(HB_PERIOD - 1));
    hb_cnt_d  = hb_fire ? 32'd0 : hb_cnt_q + 32'd1;
    hb_pend_d = hb_pend_q & ~grant_hb;
    hb_pl_d   = hb_pl_q;
    ovr_hb    = 1'b0;
    if (hb_fire) begin
      hb_pend_d = 1'b1;
      hb_pl_d   = {Meas_Lock, PWM_Duty};
      ovr_hb    = hb_pend_q & ~grant_hb;
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (!CLK_RST) begin
      hb_pend_q <= 1'b0;
      hb_pl_q   <= '0;
      hb_cnt_q  <= '0;
    end else begin
      hb_pend_q <= hb_pend_d;
      hb_pl_q   <= hb_pl_d;
      hb_cnt_q  <= hb_cnt_d;
    end
  end

  assign hb_pend = hb_pend_q;
  assign hb_pl   = hb_pl_q;
`else
  logic unused_hb;
  assign hb_pend   = 1'b0;
  assign hb_pl     = '0;
  assign ovr_hb    = 1'b0;
  assign unused_hb = ^{PWM_Duty, HB_PERIOD, grant_hb};
`endif

  always_ff @(posedge CLK_SYS) begin
    if (!CLK_RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      frame_q     <= '0;
      uart_en_q   <= 1'b0;
      uart_data_q <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= '0;
      meas_pend_q <= 1'b0;
      meas_pl_q   <= '0;
      tmo_pend_q  <= 1'b0;
      tmo_pl_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      frame_q     <= frame_d;
      uart_en_q   <= uart_en_d;
      uart_data_q <= uart_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      meas_pend_q <= meas_pend_d;
      meas_pl_q   <= meas_pl_d;
      tmo_pend_q  <= tmo_pend_d;
      tmo_pl_q    <= tmo_pl_d;
    end
  end

  assign Uart_En    = uart_en_q;
  assign Uart_Data  = uart_data_q;
  assign Frame_Done = done_q;
  assign Frame_Err  = err_q;
  assign Ovr_Cnt    = ovr_q;

endmodule

// File: tb/tb_phase_report_sched.sv
// tb/tb_phase_report_sched.sv - self-checking bench for phase_report_sched
module tb_phase_report_sched;
  localparam int HB_P = 100;
  localparam int BT   = 1023;

  logic        CLK_SYS    = 1'b0;
  logic        CLK_RST    = 1'b0;
  logic        Meas_Valid = 1'b0;
  logic [31:0] Meas_Phase = '0;
  logic        Meas_Order = 1'b0;
  logic        Meas_Lock  = 1'b0;
  logic        Tmo_Valid  = 1'b0;
  logic [31:0] PWM_Duty   = '0;
  logic        Uart_Busy  = 1'b0;
  logic        Uart_En;
  logic [7:0]  Uart_Data;
  logic        Frame_Done;
  logic        Frame_Err;
  logic [7:0]  Ovr_Cnt;

  phase_report_sched #(.HB_PERIOD(HB_P), .BUSY_TIMEOUT(BT), .SYNC_BYTE(8'hA5)) dut (
    .CLK_SYS(CLK_SYS), .CLK_RST(CLK_RST), .Meas_Valid(Meas_Valid), .Meas_Phase(Meas_Phase),
    .Meas_Order(Meas_Order), .Meas_Lock(Meas_Lock), .Tmo_Valid(Tmo_Valid), .PWM_Duty(PWM_Duty),
    .Uart_Busy(Uart_Busy), .Uart_En(Uart_En), .Uart_Data(Uart_Data), .Frame_Done(Frame_Done),
    .Frame_Err(Frame_Err), .Ovr_Cnt(Ovr_Cnt)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  int cyc = 0;
  always @(posedge CLK_SYS) cyc <= cyc + 1;

  // UART model: a strobe is captured on the falling edge, and busy is then
  // held for byte_cyc cycles. Byte number stuck_n never raises busy.
  int byte_cyc  = 10;
  int stuck_n   = -1;
  int en_cnt    = 0;
  int busy_left = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int err_t     = 0;
  int err_en    = 0;
  logic [7:0] rx_q[$];
  int         en_t_q[$];

  always @(negedge CLK_SYS) begin
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) Uart_Busy = 1'b0;
    end
    if (Uart_En === 1'b1) begin
      rx_q.push_back(Uart_Data);
      en_t_q.push_back(cyc);
      en_cnt++;
      if (en_cnt != stuck_n) begin
        Uart_Busy = 1'b1;
        busy_left = byte_cyc;
      end
    end
    if (Frame_Done === 1'b1) done_cnt++;
    if (Frame_Err === 1'b1) begin
      err_cnt++;
      err_t  = cyc;
      err_en = en_cnt;
    end
  end

  int total = 0;
  int bad   = 0;
  int rd    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame built from the framing rules.
  function automatic logic [55:0] model_frame(input int typ, input bit ord, input bit lk, input logic [31:0] v);
    int b[7];
    logic [55:0] f;
    b[0] = 'hA5;
    b[1] = typ + (lk ? 64 : 0) + (ord ? 128 : 0);
    for (int j = 0; j < 4; j++) b[2+j] = int'((v >> (8 * (3 - j))) & 32'hFF);
    b[6] = 0;
    for (int j = 1; j < 6; j++) b[6] = b[6] ^ b[j];
    f = '0;
    for (int j = 0; j < 7; j++) f = (f << 8) | 56'(b[j]);
    return f;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge CLK_SYS);
      k++;
    end
    check({tag, "_wait"}, 64'(rx_q.size() >= n), 64'd1);
  endtask

  task automatic expect_frame(input string tag, input int typ, input bit ord, input bit lk,
                              input logic [31:0] v, output int t0);
    logic [55:0] f;
    f  = model_frame(typ, ord, lk, v);
    t0 = -1;
    wait_bytes(tag, rd + 7, 4000);
    if (rx_q.size() >= rd + 7) begin
      t0 = en_t_q[rd];
      for (int j = 0; j < 7; j++)
        check($sformatf("%s_b%0d", tag, j), 64'(rx_q[rd+j]), 64'(f[8*(6-j) +: 8]));
      rd += 7;
    end
  endtask

  task automatic pulse(input bit m, input bit t, input logic [31:0] ph, input bit ord,
                       input bit lk, output int ts);
    @(negedge CLK_SYS);
    Meas_Valid = m;
    Tmo_Valid  = t;
    Meas_Phase = ph;
    Meas_Order = ord;
    Meas_Lock  = lk;
    @(negedge CLK_SYS);
    Meas_Valid = 1'b0;
    Tmo_Valid  = 1'b0;
    ts = cyc;
  endtask

  task automatic do_reset();
    @(negedge CLK_SYS);
    CLK_RST = 1'b0;
    repeat (2) @(negedge CLK_SYS);
    CLK_RST = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ts, t0, t1, tl, k, base, e0, d0, exp_ovr, nm, nt;
    logic [31:0] p1, p2, lastm, lastt;
    logic [55:0] mf;
    bit o1, l1, o2, l2, lastmo, lastml, lasttl;

    Meas_Lock = 1'b1;
    PWM_Duty  = 32'd32768;
    repeat (3) @(negedge CLK_SYS);
    check("rst_en",   64'(Uart_En),    64'd0);
    check("rst_data", 64'(Uart_Data),  64'h00);
    check("rst_done", 64'(Frame_Done), 64'd0);
    check("rst_err",  64'(Frame_Err),  64'd0);
    check("rst_ovr",  64'(Ovr_Cnt),    64'd0);
    CLK_RST = 1'b1;

`ifdef PHASE_RPT_HEARTBEAT_EN
    expect_frame("hb0", 3, 1'b0, 1'b1, 32'h8000, t0);
    expect_frame("hb1", 3, 1'b0, 1'b1, 32'h8000, t1);
    check("hb_spacing1", 64'(t1 - t0), 64'(HB_P));
    expect_frame("hb2", 3, 1'b0, 1'b1, 32'h8000, t0);
    check("hb_spacing2", 64'(t0 - t1), 64'(HB_P));
    check("hb_ovr", 64'(Ovr_Cnt), 64'd0);
`else
    repeat (350) @(negedge CLK_SYS);
    check("no_hb_frames", 64'(rx_q.size()), 64'd0);

    // Directed measurement frame, latency and held data.
    p1 = 32'h00001234;
    d0 = done_cnt;
    pulse(1'b1, 1'b0, p1, 1'b1, 1'b0, ts);
    expect_frame("meas1", 1, 1'b1, 1'b0, p1, t0);
    check("meas1_lat", 64'(t0 - ts), 64'd2);
    repeat (15) @(negedge CLK_SYS);
    check("meas1_done", 64'(done_cnt - d0), 64'd1);
    mf = model_frame(1, 1'b1, 1'b0, p1);
    check("meas1_hold", 64'(Uart_Data), 64'(mf[7:0]));
    check("meas1_ovr", 64'(Ovr_Cnt), 64'd0);

    // Simultaneous Meas and Tmo: Meas first, then one IDLE cycle.
    p1 = $urandom;
    o1 = 1'($urandom_range(0, 1));
    l1 = 1'($urandom_range(0, 1));
    pulse(1'b1, 1'b1, p1, o1, l1, ts);
    expect_frame("both_meas", 1, o1, l1, p1, t0);
    tl = (rd > 0) ? en_t_q[rd-1] : 0;
    expect_frame("both_tmo", 2, 1'b0, l1, p1, t1);
    check("both_gap", 64'(t1 - tl), 64'(byte_cyc + 3));
    check("both_ovr", 64'(Ovr_Cnt), 64'd0);
    repeat (20) @(negedge CLK_SYS);

    // Random overwrite rounds while a frame is in flight.
    exp_ovr = 0;
    for (int r = 0; r < 3; r++) begin
      p1 = $urandom;
      o1 = 1'($urandom_range(0, 1));
      l1 = 1'($urandom_range(0, 1));
      pulse(1'b1, 1'b0, p1, o1, l1, ts);
      wait_bytes("rnd_first", rd + 1, 100);
      nm = $urandom_range(1, 4);
      nt = $urandom_range(0, 3);
      lastm = '0; lastt = '0; lastmo = 1'b0; lastml = 1'b0; lasttl = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (i < nm || i < nt) begin
          p2 = $urandom;
          o2 = 1'($urandom_range(0, 1));
          l2 = 1'($urandom_range(0, 1));
          pulse(i < nm, i < nt, p2, o2, l2, ts);
          if (i < nm) begin lastm = p2; lastmo = o2; lastml = l2; end
          if (i < nt) begin lastt = p2; lasttl = l2; end
        end
      end
      exp_ovr = sat255(exp_ovr + (nm - 1) + ((nt > 0) ? nt - 1 : 0));
      check($sformatf("rnd%0d_ovr", r), 64'(Ovr_Cnt), 64'(exp_ovr));
      expect_frame("rnd_cur", 1, o1, l1, p1, t0);
      expect_frame("rnd_meas", 1, lastmo, lastml, lastm, t0);
      if (nt > 0) expect_frame("rnd_tmo", 2, 1'b0, lasttl, lastt, t0);
      repeat (20) @(negedge CLK_SYS);
    end

    // Overrun counter saturation during a slow frame.
    byte_cyc = 150;
    p1 = $urandom;
    pulse(1'b1, 1'b0, p1, 1'b0, 1'b1, ts);
    wait_bytes("sat_first", rd + 1, 100);
    for (int i = 0; i < 300; i++) begin
      p2 = $urandom;
      o2 = 1'($urandom_range(0, 1));
      l2 = 1'($urandom_range(0, 1));
      pulse(1'b1, 1'b0, p2, o2, l2, ts);
      lastm = p2; lastmo = o2; lastml = l2;
    end
    exp_ovr = sat255(exp_ovr + 299);
    check("ovr_sat", 64'(Ovr_Cnt), 64'(exp_ovr));
    expect_frame("sat_cur", 1, 1'b0, 1'b1, p1, t0);
    expect_frame("sat_last", 1, lastmo, lastml, lastm, t0);
    byte_cyc = 10;
    repeat (200) @(negedge CLK_SYS);

    // Busy never rises after byte 2: abort, then serve the pending request.
    do_reset();
    check("to_ovr_reset", 64'(Ovr_Cnt), 64'd0);
    check("to_no_stray", 64'(rx_q.size()), 64'(rd));
    base = en_cnt;
    stuck_n = base + 3;
    e0 = err_cnt;
    p1 = $urandom;
    o1 = 1'($urandom_range(0, 1));
    l1 = 1'($urandom_range(0, 1));
    pulse(1'b1, 1'b0, p1, o1, l1, ts);
    wait_bytes("to_b2", rd + 3, 200);
    p2 = $urandom;
    o2 = 1'($urandom_range(0, 1));
    l2 = 1'($urandom_range(0, 1));
    pulse(1'b1, 1'b0, p2, o2, l2, ts);
    k = 0;
    while (err_cnt == e0 && k < 1500) begin
      @(negedge CLK_SYS);
      k++;
    end
    check("to_err", 64'(err_cnt - e0), 64'd1);
    check("to_no_more_en", 64'(err_en), 64'(base + 3));
    if (rx_q.size() >= rd + 3) begin
      check("to_dist", 64'(err_t - en_t_q[rd+2]), 64'(BT));
      mf = model_frame(1, o1, l1, p1);
      for (int j = 0; j < 3; j++)
        check($sformatf("to_b%0d", j), 64'(rx_q[rd+j]), 64'(mf[8*(6-j) +: 8]));
      rd += 3;
    end
    stuck_n = -1;
    expect_frame("to_next", 1, o2, l2, p2, t0);
    repeat (20) @(negedge CLK_SYS);

    // Reset in the middle of a frame, with a Tmo request pending.
    p1 = $urandom;
    pulse(1'b1, 1'b0, p1, 1'b1, 1'b1, ts);
    wait_bytes("rm_b3", rd + 4, 200);
    p2 = $urandom;
    pulse(1'b0, 1'b1, p2, 1'b0, 1'b1, ts);
    @(negedge CLK_SYS);
    CLK_RST = 1'b0;
    @(negedge CLK_SYS);
    check("rm_en",   64'(Uart_En),    64'd0);
    check("rm_data", 64'(Uart_Data),  64'h00);
    check("rm_done", 64'(Frame_Done), 64'd0);
    check("rm_err",  64'(Frame_Err),  64'd0);
    check("rm_ovr",  64'(Ovr_Cnt),    64'd0);
    CLK_RST = 1'b1;
    repeat (60) @(negedge CLK_SYS);
    check("rm_quiet", 64'(rx_q.size()), 64'(rd + 4));
    rd = rd + 4;
    p2 = $urandom;
    o2 = 1'($urandom_range(0, 1));
    l2 = 1'($urandom_range(0, 1));
    pulse(1'b1, 1'b0, p2, o2, l2, ts);
    expect_frame("rm_next", 1, o2, l2, p2, t0);
    check("rm_next_lat", 64'(t0 - ts), 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
